// File: rtl/pipe_out_arbiter.sv
// pipe_out_arbiter
// Shares one FrontPanel pipe-out endpoint between N_CH on-FPGA sample
// streams. A round-robin scheduler takes one 16-bit word per grant over a
// valid/ready handshake and queues it in a first-word-fall-through FIFO
// that the host drains with the pipe-out read strobe.
//
// Compile-time option: PIPE_ARB_HEADER_EN
//   defined   - every sample is queued as a header word {4'hA, channel, seq}
//               followed by the data word; the scheduler waits for 2 free
//               FIFO words before granting.
//   undefined - only data words are queued; 1 free word is enough.
//
// Everything runs on the rising edge of ti_clk; rst_n is an asynchronous,
// active-low reset.
module pipe_out_arbiter #(
    parameter int  N_CH  = 4,
    parameter int  DEPTH = 512,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic               ti_clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    ch_valid,
    input  logic [16*N_CH-1:0] ch_data,
    output logic [N_CH-1:0]    ch_ready,
    input  logic               pipe_read,
    output logic [15:0]        pipe_data,
    output logic [CW-1:0]      fifo_count,
    output logic               underrun,
    input  logic               clr_underrun
);

    // FIFO storage index width; the extra pointer bit distinguishes full
    // from empty so the occupancy is simply the pointer difference.
    localparam int AW = CW - 1;

    // The search always restarts at channel 0 after reset.
    localparam logic [3:0] LAST_INIT = 4'(N_CH - 1);

`ifdef PIPE_ARB_HEADER_EN
    typedef enum logic [1:0] {
        ARB  = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    // A grant is only issued when both the header and the data word fit.
    localparam logic [CW-1:0] GRANT_MAX_COUNT = CW'(DEPTH - 2);
`else
    typedef enum logic [1:0] {
        ARB  = 2'd0,
        DATA = 2'd2
    } state_t;

    localparam logic [CW-1:0] GRANT_MAX_COUNT = CW'(DEPTH - 1);
`endif

    state_t          state_reg;
    state_t          state_next;
    logic [3:0]      grant_reg;
    logic [3:0]      grant_next;
    logic [3:0]      last_grant_reg;

`ifdef PIPE_ARB_HEADER_EN
    logic [7:0]      seq_reg;
`endif

    // Channel view widened to the 16-channel maximum so the 4-bit grant can
    // index it directly; unused slots read as idle.
    logic [15:0]     ch_word [16];
    logic [15:0]     valid_ext;

    // Round-robin search result.
    logic            pick_found;
    logic [3:0]      pick_ch;

    // Arbiter-side FIFO write request.
    logic            push;
    logic [15:0]     push_data;

    // FIFO state.
    logic [15:0]     mem [DEPTH];
    logic [CW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx_next;
    logic            pop;
    logic            underrun_event;
    logic            space_ok;
    logic [15:0]     pipe_data_reg;
    logic [15:0]     pipe_data_next;
    logic            underrun_reg;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_ch
            if (gi < N_CH) begin : g_used
                assign ch_word[gi]   = ch_data[16*gi +: 16];
                assign valid_ext[gi] = ch_valid[gi];
            end else begin : g_pad
                assign ch_word[gi]   = 16'h0000;
                assign valid_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // The ready pulse belongs to the cycle in which the granted word is
    // pushed, so it is decoded straight from the state register.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
            assign ch_ready[gi] = (state_reg == DATA) && (grant_reg == 4'(gi));
        end
    endgenerate

    assign count          = wr_ptr_reg - rd_ptr_reg;
    assign wr_idx         = wr_ptr_reg[AW-1:0];
    assign rd_idx_next    = rd_ptr_reg[AW-1:0] + AW'(1);
    assign pop            = pipe_read && (count != '0);
    assign underrun_event = pipe_read && (count == '0);
    assign space_ok       = (count <= GRANT_MAX_COUNT);

    assign pipe_data  = pipe_data_reg;
    assign fifo_count = count;
    assign underrun   = underrun_reg;

    // Round-robin pick: first valid channel starting one past the last grant.
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_ch    = last_grant_reg;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(last_grant_reg) + i) % N_CH;
            if (!pick_found && valid_ext[4'(idx)]) begin
                pick_found = 1'b1;
                pick_ch    = 4'(idx);
            end
        end
    end

    // Scheduler next state and the word it pushes this cycle.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        push       = 1'b0;
        push_data  = 16'h0000;
        case (state_reg)
            ARB: begin
                if (space_ok && pick_found) begin
                    grant_next = pick_ch;
`ifdef PIPE_ARB_HEADER_EN
                    state_next = HDR;
`else
                    state_next = DATA;
`endif
                end
            end
`ifdef PIPE_ARB_HEADER_EN
            HDR: begin
                push       = 1'b1;
                push_data  = {4'hA, grant_reg, seq_reg};
                state_next = DATA;
            end
`endif
            DATA: begin
                push       = 1'b1;
                push_data  = ch_word[grant_reg];
                state_next = ARB;
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    // Scheduler registers; last_grant moves only when a word is accepted.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB;
            grant_reg      <= LAST_INIT;
            last_grant_reg <= LAST_INIT;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            if (state_reg == DATA) begin
                last_grant_reg <= grant_reg;
            end
        end
    end

`ifdef PIPE_ARB_HEADER_EN
    // Sample sequence number, advanced once per accepted sample.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_reg <= 8'd0;
        end else if (state_reg == DATA) begin
            seq_reg <= seq_reg + 8'd1;
        end
    end
`endif

    // FIFO storage write port (no reset so it maps onto RAM).
    always_ff @(posedge ti_clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    // FIFO pointers; the scheduler never pushes into a full FIFO.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + CW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + CW'(1);
            end
        end
    end

    // Next head word: the entry behind the popped one, the word being pushed
    // when it becomes the only entry, or zero when the FIFO is left empty.
    always_comb begin
        pipe_data_next = pipe_data_reg;
        if (pop) begin
            if (count > CW'(1)) begin
                pipe_data_next = mem[rd_idx_next];
            end else if (push) begin
                pipe_data_next = push_data;
            end else begin
                pipe_data_next = 16'h0000;
            end
        end else if (count == '0) begin
            pipe_data_next = push ? push_data : 16'h0000;
        end
    end

    // Registered head word presented to the pipe-out data input.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_data_reg <= 16'h0000;
        end else begin
            pipe_data_reg <= pipe_data_next;
        end
    end

    // Sticky underrun flag; a new empty read wins over a clear.
    always_ff @(posedge ti_clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_reg <= 1'b0;
        end else if (underrun_event) begin
            underrun_reg <= 1'b1;
        end else if (clr_underrun) begin
            underrun_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_out_arbiter.sv
// Self-checking bench for pipe_out_arbiter (N_CH=4, DEPTH=4). Randomised
// requesters and host reads are checked cycle by cycle against a queue-based
// model of the spec, plus directed checks for the spec's test plan. Honors
// PIPE_ARB_HEADER_EN in the same way as the design.
module tb_pipe_out_arbiter;

    localparam int N_CH  = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef PIPE_ARB_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif
    localparam int NEED = HDR_EN ? 2 : 1;   // FIFO words per sample

    logic               ti_clk = 1'b0;
    logic               rst_n;
    logic [N_CH-1:0]    ch_valid;
    logic [16*N_CH-1:0] ch_data;
    logic [N_CH-1:0]    ch_ready;
    logic               pipe_read;
    logic [15:0]        pipe_data;
    logic [CW-1:0]      fifo_count;
    logic               underrun;
    logic               clr_underrun;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue, a countdown of cycles until
    // the granted word is accepted (2 = header due, 1 = data due, 0 = idle).
    logic [15:0]     mq [$];
    int              m_phase;
    int              m_grant;
    int              m_last;
    logic [7:0]      m_seq;
    logic            m_und;
    logic [N_CH-1:0] m_acc;

    pipe_out_arbiter #(.N_CH(N_CH), .DEPTH(DEPTH)) dut (
        .ti_clk       (ti_clk),
        .rst_n        (rst_n),
        .ch_valid     (ch_valid),
        .ch_data      (ch_data),
        .ch_ready     (ch_ready),
        .pipe_read    (pipe_read),
        .pipe_data    (pipe_data),
        .fifo_count   (fifo_count),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    always #5 ti_clk = ~ti_clk;

    function automatic logic [N_CH-1:0] m_ready();
        return (m_phase == 1) ? (N_CH'(1) << m_grant) : '0;
    endfunction

    function automatic logic [15:0] m_head();
        return (mq.size() > 0) ? mq[0] : 16'h0000;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_phase = 0;
        m_grant = 0;
        m_last  = N_CH - 1;
        m_seq   = 8'd0;
        m_und   = 1'b0;
        m_acc   = '0;
    endtask

    // One clock edge of the spec's behaviour, using the inputs present now.
    task automatic model_update();
        int sz;
        logic [15:0] junk;
        sz    = mq.size();
        m_acc = m_ready();
        if (pipe_read && sz == 0) m_und = 1'b1;
        else if (clr_underrun)    m_und = 1'b0;
        if (pipe_read && sz > 0) junk = mq.pop_front();
        if (m_phase == 2) begin
            mq.push_back({4'hA, 4'(m_grant), m_seq});
            m_phase = 1;
        end else if (m_phase == 1) begin
            mq.push_back(ch_data[16*m_grant +: 16]);
            m_seq   = m_seq + 8'd1;
            m_last  = m_grant;
            m_phase = 0;
        end else if ((DEPTH - sz) >= NEED) begin
            bit found;
            found = 1'b0;
            for (int i = 1; i <= N_CH; i++) begin
                int c;
                c = (m_last + i) % N_CH;
                if (!found && ch_valid[c]) begin
                    found   = 1'b1;
                    m_grant = c;
                    m_phase = NEED;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge ti_clk);
        if (rst_n === 1'b1) model_update();
        #1;
    endtask

    // Random requesters: drop a word once accepted, hold it otherwise.
    task automatic drive(input int p_valid, input int p_read);
        for (int k = 0; k < N_CH; k++) begin
            if (m_acc[k]) ch_valid[k] = 1'b0;
            if (!ch_valid[k] && int'($urandom_range(99)) < p_valid) begin
                ch_valid[k] = 1'b1;
                ch_data[16*k +: 16] = 16'($urandom);
            end
        end
        pipe_read = (int'($urandom_range(99)) < p_read);
    endtask

    // Let pending requests finish, empty the FIFO and clear underrun.
    task automatic drain();
        int guard;
        guard = 0;
        clr_underrun = 1'b0;
        while ((ch_valid != '0 || m_phase != 0 || mq.size() != 0) && guard < 200) begin
            drive(0, 100);
            tick();
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("FAIL drain_timeout: got %0d cycles, required < 200", guard);
        end
        pipe_read = 1'b0;
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ch_valid = '0;
        ch_data = '0;
        pipe_read = 1'b0;
        clr_underrun = 1'b0;
        model_reset();
        repeat (3) tick();
        checks++; if (ch_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b required 0", ch_ready); end
        checks++; if (pipe_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h required 0000", pipe_data); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b required 0", underrun); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int lat;
        int pulses;
        lat = -1;
        pulses = 0;
        ch_data = '0;
        ch_data[15:0] = 16'h1234;
        ch_valid = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            tick();
            checks++; if (ch_ready !== m_ready()) begin errors++; $display("FAIL single_ready: got %b required %b", ch_ready, m_ready()); end
            checks++; if (pipe_data !== m_head()) begin errors++; $display("FAIL single_data: got %h required %h", pipe_data, m_head()); end
            checks++; if (fifo_count !== CW'(mq.size())) begin errors++; $display("FAIL single_count: got %0d required %0d", fifo_count, mq.size()); end
            if (ch_ready[0] === 1'b1) begin
                pulses++;
                if (lat < 0) lat = c;
            end
            if (m_acc[0]) ch_valid = 4'b0000;
        end
        checks++; if (lat !== (HDR_EN ? 2 : 1)) begin errors++; $display("FAIL single_latency: got %0d required %0d", lat, HDR_EN ? 2 : 1); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL single_pulses: got %0d required 1", pulses); end
        checks++; if (fifo_count !== CW'(NEED)) begin errors++; $display("FAIL single_fill: got %0d required %0d", fifo_count, NEED); end
        checks++; if (pipe_data !== (HDR_EN ? 16'hA000 : 16'h1234)) begin errors++; $display("FAIL single_first: got %h required %h", pipe_data, HDR_EN ? 16'hA000 : 16'h1234); end
        pipe_read = 1'b1;
        tick();
        pipe_read = 1'b0;
        checks++; if (pipe_data !== (HDR_EN ? 16'h1234 : 16'h0000)) begin errors++; $display("FAIL single_second: got %h required %h", pipe_data, HDR_EN ? 16'h1234 : 16'h0000); end
        checks++; if (fifo_count !== CW'(NEED - 1)) begin errors++; $display("FAIL single_popcount: got %0d required %0d", fifo_count, NEED - 1); end
    endtask

    task automatic test_round_robin();
        int pulses [N_CH];
        int last_c;
        int n_model;
        int total;
        int mn;
        int mx;
        drain();
        for (int k = 0; k < N_CH; k++) pulses[k] = 0;
        last_c = -1;
        n_model = 0;
        for (int c = 0; c < 1100; c++) begin
            drive(100, 100);
            tick();
            checks++; if (ch_ready !== m_ready()) begin errors++; $display("FAIL rr_ready: got %b required %b", ch_ready, m_ready()); end
            checks++; if (pipe_data !== m_head()) begin errors++; $display("FAIL rr_data: got %h required %h", pipe_data, m_head()); end
            checks++; if (fifo_count !== CW'(mq.size())) begin errors++; $display("FAIL rr_count: got %0d required %0d", fifo_count, mq.size()); end
            checks++; if (underrun !== m_und) begin errors++; $display("FAIL rr_underrun: got %b required %b", underrun, m_und); end
            if (m_acc != '0) n_model++;
            if (ch_ready != '0) begin
                for (int k = 0; k < N_CH; k++) pulses[k] += int'(ch_ready[k]);
                if (last_c >= 0) begin
                    checks++;
                    if (c - last_c != (HDR_EN ? 3 : 2)) begin
                        errors++;
                        $display("FAIL rr_spacing: got %0d cycles required %0d", c - last_c, HDR_EN ? 3 : 2);
                    end
                end
                last_c = c;
            end
        end
        total = 0;
        mn = pulses[0];
        mx = pulses[0];
        for (int k = 0; k < N_CH; k++) begin
            total += pulses[k];
            if (pulses[k] < mn) mn = pulses[k];
            if (pulses[k] > mx) mx = pulses[k];
        end
        checks++; if (mx - mn > 1) begin errors++; $display("FAIL rr_fairness: got spread %0d required <= 1", mx - mn); end
        checks++; if (total < 300) begin errors++; $display("FAIL rr_samples: got %0d required >= 300", total); end
        checks++; if (total > n_model + 1 || total < n_model - 1) begin errors++; $display("FAIL rr_total: got %0d required about %0d", total, n_model); end
    endtask

    task automatic test_full();
        int late;
        int after;
        drain();
        late = 0;
        for (int c = 0; c < 20; c++) begin
            drive(100, 0);
            tick();
            checks++; if (ch_ready !== m_ready()) begin errors++; $display("FAIL full_ready: got %b required %b", ch_ready, m_ready()); end
            checks++; if (pipe_data !== m_head()) begin errors++; $display("FAIL full_data: got %h required %h", pipe_data, m_head()); end
            if (c >= 10 && ch_ready != '0) late++;
        end
        checks++; if (fifo_count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d required %0d", fifo_count, DEPTH); end
        checks++; if (late !== 0) begin errors++; $display("FAIL full_stall: got %0d pulses required 0", late); end
        after = 0;
        for (int c = 0; c < 14; c++) begin
            drive(100, 0);
            pipe_read = (c < 2);
            tick();
            checks++; if (ch_ready !== m_ready()) begin errors++; $display("FAIL full_ready2: got %b required %b", ch_ready, m_ready()); end
            checks++; if (pipe_data !== m_head()) begin errors++; $display("FAIL full_data2: got %h required %h", pipe_data, m_head()); end
            if (ch_ready != '0) after++;
        end
        pipe_read = 1'b0;
        checks++; if (after !== (HDR_EN ? 1 : 2)) begin errors++; $display("FAIL full_refill: got %0d samples required %0d", after, HDR_EN ? 1 : 2); end
        checks++; if (fifo_count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count2: got %0d required %0d", fifo_count, DEPTH); end
    endtask

    task automatic test_underrun();
        drain();
        pipe_read = 1'b1;
        tick();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL und_set: got %b required 1", underrun); end
        checks++; if (pipe_data !== 16'h0000) begin errors++; $display("FAIL und_data: got %h required 0000", pipe_data); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL und_count: got %0d required 0", fifo_count); end
        clr_underrun = 1'b1;
        tick();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL und_setwins: got %b required 1", underrun); end
        pipe_read = 1'b0;
        tick();
        clr_underrun = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL und_clear: got %b required 0", underrun); end
        // Pointers must still line up: a fresh sample comes out intact.
        ch_data[63:48] = 16'($urandom);
        ch_valid = 4'b1000;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (m_acc[3]) ch_valid = 4'b0000;
            checks++; if (pipe_data !== m_head()) begin errors++; $display("FAIL und_after: got %h required %h", pipe_data, m_head()); end
            checks++; if (fifo_count !== CW'(mq.size())) begin errors++; $display("FAIL und_cnt2: got %0d required %0d", fifo_count, mq.size()); end
        end
    endtask

    task automatic test_push_pop();
        int hits;
        logic forced;
        hits = 0;
        drain();
        for (int c = 0; c < 3000 && hits < 6; c++) begin
            drive(60, 35);
            forced = (mq.size() == 3) && (m_phase != 0);
            if (forced) pipe_read = 1'b1;
            tick();
            checks++; if (ch_ready !== m_ready()) begin errors++; $display("FAIL pp_ready: got %b required %b", ch_ready, m_ready()); end
            checks++; if (pipe_data !== m_head()) begin errors++; $display("FAIL pp_data: got %h required %h", pipe_data, m_head()); end
            checks++; if (fifo_count !== CW'(mq.size())) begin errors++; $display("FAIL pp_count: got %0d required %0d", fifo_count, mq.size()); end
            checks++; if (underrun !== m_und) begin errors++; $display("FAIL pp_underrun: got %b required %b", underrun, m_und); end
            if (forced) begin
                hits++;
                checks++; if (fifo_count !== CW'(3)) begin errors++; $display("FAIL pp_hold3: got %0d required 3", fifo_count); end
            end
        end
        checks++; if (hits == 0) begin errors++; $display("FAIL pp_reached: got 0 push+pop at count 3 required >= 1"); end
        pipe_read = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard;
        logic [15:0] d;
        drain();
        d = 16'($urandom);
        ch_data[47:32] = d;
        ch_valid = 4'b0100;
        pipe_read = 1'b0;
        guard = 0;
        while (m_phase != 1 && guard < 10) begin
            tick();
            guard++;
        end
        checks++; if (guard >= 10) begin errors++; $display("FAIL mid_grant: got %0d cycles required < 10", guard); end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (ch_ready !== '0) begin errors++; $display("FAIL mid_ready: got %b required 0", ch_ready); end
        checks++; if (fifo_count !== '0) begin errors++; $display("FAIL mid_count: got %0d required 0", fifo_count); end
        checks++; if (pipe_data !== 16'h0000) begin errors++; $display("FAIL mid_data: got %h required 0000", pipe_data); end
        tick();
        tick();
        rst_n = 1'b1;
        guard = 0;
        while (ch_ready === '0 && guard < 10) begin
            tick();
            guard++;
            checks++; if (ch_ready !== m_ready()) begin errors++; $display("FAIL mid_ready2: got %b required %b", ch_ready, m_ready()); end
        end
        checks++; if (ch_ready !== 4'b0100) begin errors++; $display("FAIL mid_serve: got %b required 0100", ch_ready); end
        checks++; if (pipe_data !== (HDR_EN ? 16'hA200 : 16'h0000)) begin errors++; $display("FAIL mid_header: got %h required %h", pipe_data, HDR_EN ? 16'hA200 : 16'h0000); end
        tick();
        ch_valid = 4'b0000;
        checks++; if (pipe_data !== (HDR_EN ? 16'hA200 : d)) begin errors++; $display("FAIL mid_head2: got %h required %h", pipe_data, HDR_EN ? 16'hA200 : d); end
        checks++; if (fifo_count !== CW'(NEED)) begin errors++; $display("FAIL mid_count2: got %0d required %0d", fifo_count, NEED); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_underrun();
        test_push_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
